// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants for the MIPS ID/EX control stage.
// Contents: opcode and funct field values, 3-bit ALU control codes,
// the aluop encoding passed from the main decoder to the ALU decoder,
// and the ALU code held by an empty (bubble) ID/EX slot.
package mips_ctrl_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU control codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_INV = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Main decoder -> ALU decoder operation class
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_INV   = 2'b11
   } aluop_t;

   // An empty ID/EX slot is all zero except for an "add" ALU code
   localparam logic [2:0] BUBBLE_ALU_CTRL = ALU_ADD;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder.
// Ports:
//   aluop       in   operation class from the main decoder
//   funct       in   R-type funct field
//   alu_control out  3-bit ALU control code
//   illegal     out  instruction cannot be executed (bad opcode or funct)
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       illegal
);

   always_comb begin
      alu_control = ALU_INV;
      illegal     = 1'b0;
      case (aluop)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLT:  alu_control = ALU_SLT;
               default: begin
                  alu_control = ALU_INV;
                  illegal     = 1'b1;
               end
            endcase
         end
         default: begin
            alu_control = ALU_INV;
            illegal     = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_control_stage.sv
// MIPS decode stage and ID/EX pipeline register.
// Decodes the IF/ID instruction into datapath controls, registers them
// into ID/EX, inserts a bubble on a load-use hazard, holds on a
// downstream stall and kills the slot on a branch/jump flush.
// Optional feature: define CTRL_IMM_OPS_EN to decode addi/slti/andi/ori;
// without it those opcodes are treated as illegal.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   if_id_valid/instr     incoming instruction slot
//   ex_stall_i            hold ID/EX contents
//   flush_i               replace ID/EX contents with a bubble
//   hazard_stall_o        combinational: hold PC and IF/ID this cycle
//   ex_*                  registered ID/EX controls and fields
module id_ex_control_stage
   import mips_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ALU_CTRL_W = 3
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  if_id_valid,
   input  logic [31:0]           if_id_instr,
   input  logic                  ex_stall_i,
   input  logic                  flush_i,
   output logic                  hazard_stall_o,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_mem_to_reg,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic                  ex_alu_src,
   output logic                  ex_reg_dst,
   output logic [ALU_CTRL_W-1:0] ex_alu_control,
   output logic [4:0]            ex_rs,
   output logic [4:0]            ex_rt,
   output logic [4:0]            ex_rd,
   output logic [XLEN-1:0]       ex_imm_ext,
   output logic                  ex_illegal
);

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  branch;
      logic                  jump;
      logic                  alu_src;
      logic                  reg_dst;
      logic [ALU_CTRL_W-1:0] alu_control;
      logic [4:0]            rs;
      logic [4:0]            rt;
      logic [4:0]            rd;
      logic [XLEN-1:0]       imm_ext;
      logic                  illegal;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '{alu_control: ALU_CTRL_W'(BUBBLE_ALU_CTRL), default: '0};

   // Instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rs_f, rt_f, rd_f;
   logic [5:0]  funct;
   logic [15:0] imm16;

   assign opcode = if_id_instr[31:26];
   assign rs_f   = if_id_instr[25:21];
   assign rt_f   = if_id_instr[20:16];
   assign rd_f   = if_id_instr[15:11];
   assign funct  = if_id_instr[5:0];
   assign imm16  = if_id_instr[15:0];

   aluop_t     aluop;
   logic       rt_is_source;
   logic       sign_ext;
   logic       imm_op;
   logic [2:0] imm_alu_ctrl;
   logic [2:0] dec_alu_ctrl;
   logic       dec_illegal;
   idex_t      raw_ctrl;
   idex_t      dec;
   idex_t      ex_reg;
   idex_t      ex_next;
   logic       hazard;

   // Main decoder: control bits and the ALU operation class
   always_comb begin
      aluop        = ALUOP_INV;
      rt_is_source = 1'b0;
      sign_ext     = 1'b0;
      imm_op       = 1'b0;
      imm_alu_ctrl = ALU_ADD;
      raw_ctrl     = '0;
      case (opcode)
         OP_RTYPE: begin
            aluop              = ALUOP_FUNCT;
            rt_is_source       = 1'b1;
            raw_ctrl.reg_write = 1'b1;
            raw_ctrl.reg_dst   = 1'b1;
         end
         OP_LW: begin
            aluop               = ALUOP_ADD;
            sign_ext            = 1'b1;
            raw_ctrl.reg_write  = 1'b1;
            raw_ctrl.mem_read   = 1'b1;
            raw_ctrl.mem_to_reg = 1'b1;
            raw_ctrl.alu_src    = 1'b1;
         end
         OP_SW: begin
            aluop              = ALUOP_ADD;
            sign_ext           = 1'b1;
            rt_is_source       = 1'b1;
            raw_ctrl.mem_write = 1'b1;
            raw_ctrl.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            aluop           = ALUOP_SUB;
            sign_ext        = 1'b1;
            rt_is_source    = 1'b1;
            raw_ctrl.branch = 1'b1;
         end
         OP_J: begin
            aluop         = ALUOP_ADD;
            raw_ctrl.jump = 1'b1;
         end
`ifdef CTRL_IMM_OPS_EN
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            // ALU code comes straight from the opcode, not from funct
            aluop              = ALUOP_ADD;
            imm_op             = 1'b1;
            raw_ctrl.reg_write = 1'b1;
            raw_ctrl.alu_src   = 1'b1;
            case (opcode)
               OP_ADDI: begin imm_alu_ctrl = ALU_ADD; sign_ext = 1'b1; end
               OP_SLTI: begin imm_alu_ctrl = ALU_SLT; sign_ext = 1'b1; end
               OP_ANDI: imm_alu_ctrl = ALU_AND;
               default: imm_alu_ctrl = ALU_OR;
            endcase
         end
`endif
         default: aluop = ALUOP_INV;
      endcase
   end

   mips_alu_decoder u_alu_dec (
      .aluop       (aluop),
      .funct       (funct),
      .alu_control (dec_alu_ctrl),
      .illegal     (dec_illegal)
   );

   // Assemble the decoded slot; opcodes without a sign-extended
   // immediate carry the raw 16 bits zero-extended.
   always_comb begin
      dec             = raw_ctrl;
      dec.valid       = 1'b1;
      dec.rs          = rs_f;
      dec.rt          = rt_f;
      dec.rd          = rd_f;
      dec.imm_ext     = sign_ext ? {{(XLEN-16){imm16[15]}}, imm16}
                                 : {{(XLEN-16){1'b0}}, imm16};
      dec.alu_control = ALU_CTRL_W'(imm_op ? imm_alu_ctrl : dec_alu_ctrl);
      dec.illegal     = dec_illegal;
      if (dec_illegal) begin
         // An illegal instruction must have no side effects downstream
         dec.reg_write   = 1'b0;
         dec.mem_read    = 1'b0;
         dec.mem_write   = 1'b0;
         dec.mem_to_reg  = 1'b0;
         dec.branch      = 1'b0;
         dec.jump        = 1'b0;
         dec.alu_src     = 1'b0;
         dec.reg_dst     = 1'b0;
         dec.alu_control = ALU_CTRL_W'(ALU_INV);
      end
   end

   // Load in EX whose destination is read by the instruction in ID
   assign hazard = if_id_valid & ex_reg.valid & ex_reg.mem_read &
                   (ex_reg.rt != 5'd0) &
                   ((ex_reg.rt == rs_f) | ((ex_reg.rt == rt_f) & rt_is_source));

   // A flush overrides everything, so nothing upstream needs to hold
   assign hazard_stall_o = ~flush_i & (hazard | ex_stall_i);

   always_comb begin
      if (flush_i)
         ex_next = IDEX_BUBBLE;
      else if (ex_stall_i)
         ex_next = ex_reg;
      else if (hazard || !if_id_valid)
         ex_next = IDEX_BUBBLE;
      else
         ex_next = dec;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ex_reg <= IDEX_BUBBLE;
      else
         ex_reg <= ex_next;
   end

   assign ex_valid       = ex_reg.valid;
   assign ex_reg_write   = ex_reg.reg_write;
   assign ex_mem_read    = ex_reg.mem_read;
   assign ex_mem_write   = ex_reg.mem_write;
   assign ex_mem_to_reg  = ex_reg.mem_to_reg;
   assign ex_branch      = ex_reg.branch;
   assign ex_jump        = ex_reg.jump;
   assign ex_alu_src     = ex_reg.alu_src;
   assign ex_reg_dst     = ex_reg.reg_dst;
   assign ex_alu_control = ex_reg.alu_control;
   assign ex_rs          = ex_reg.rs;
   assign ex_rt          = ex_reg.rt;
   assign ex_rd          = ex_reg.rd;
   assign ex_imm_ext     = ex_reg.imm_ext;
   assign ex_illegal     = ex_reg.illegal;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Testbench for id_ex_control_stage: table of single-instruction decode
// vectors followed by hand-written reset, load-use, stall and flush
// sequences. Define CTRL_IMM_OPS_EN for both bench and RTL to exercise
// the immediate-ALU opcodes.
module tb_id_ex_control_stage;

   logic        clk;
   logic        reset_n;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic        ex_stall_i;
   logic        flush_i;
   logic        hazard_stall_o;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        ex_branch, ex_jump, ex_alu_src, ex_reg_dst;
   logic [2:0]  ex_alu_control;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_imm_ext;
   logic        ex_illegal;

   int checks = 0;
   int errors = 0;

   id_ex_control_stage dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .ex_stall_i     (ex_stall_i),
      .flush_i        (flush_i),
      .hazard_stall_o (hazard_stall_o),
      .ex_valid       (ex_valid),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_read    (ex_mem_read),
      .ex_mem_write   (ex_mem_write),
      .ex_mem_to_reg  (ex_mem_to_reg),
      .ex_branch      (ex_branch),
      .ex_jump        (ex_jump),
      .ex_alu_src     (ex_alu_src),
      .ex_reg_dst     (ex_reg_dst),
      .ex_alu_control (ex_alu_control),
      .ex_rs          (ex_rs),
      .ex_rt          (ex_rt),
      .ex_rd          (ex_rd),
      .ex_imm_ext     (ex_imm_ext),
      .ex_illegal     (ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        m2r;
      logic        br;
      logic        j;
      logic        asrc;
      logic        rdst;
      logic [2:0]  alu;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      exp_t        exp;
   } vec_t;

   function automatic exp_t mk(input logic v, rw, mr, mw, m2r, br, j, asrc, rdst,
                               input logic [2:0] alu, input logic [4:0] rs, rt, rd,
                               input logic [31:0] imm, input logic ill);
      exp_t e;
      e = '{v, rw, mr, mw, m2r, br, j, asrc, rdst, alu, rs, rt, rd, imm, ill};
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a = '{ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
            ex_branch, ex_jump, ex_alu_src, ex_reg_dst, ex_alu_control,
            ex_rs, ex_rt, ex_rd, ex_imm_ext, ex_illegal};
      return a;
   endfunction

   task automatic check_vec(input string name, input exp_t exp);
      exp_t act;
      act = actual();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else
         $display("ok   %s: %h", name, act);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end else
         $display("ok   %s: %b", name, act);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_LW     = 32'h8C220004;  // lw  $2,4($1)
   localparam logic [31:0] I_ADD_R2 = 32'h00441820;  // add $3,$2,$4

   vec_t vecs[17];
   exp_t bubble, lw_exp, add_r2_exp;

   initial begin
      bubble     = mk(0,0,0,0,0,0,0,0,0,3'b010,5'd0,5'd0,5'd0,32'h0,0);
      lw_exp     = mk(1,1,1,0,1,0,0,1,0,3'b010,5'd1,5'd2,5'd0,32'h4,0);
      add_r2_exp = mk(1,1,0,0,0,0,0,0,1,3'b010,5'd2,5'd4,5'd3,32'h1820,0);

      vecs[0]  = '{32'h00221820, 1, mk(1,1,0,0,0,0,0,0,1,3'b010,5'd1,5'd2,5'd3,32'h1820,0)};
      vecs[1]  = '{32'h00221822, 1, mk(1,1,0,0,0,0,0,0,1,3'b110,5'd1,5'd2,5'd3,32'h1822,0)};
      vecs[2]  = '{32'h00221824, 1, mk(1,1,0,0,0,0,0,0,1,3'b000,5'd1,5'd2,5'd3,32'h1824,0)};
      vecs[3]  = '{32'h00221825, 1, mk(1,1,0,0,0,0,0,0,1,3'b001,5'd1,5'd2,5'd3,32'h1825,0)};
      vecs[4]  = '{32'h0022182A, 1, mk(1,1,0,0,0,0,0,0,1,3'b111,5'd1,5'd2,5'd3,32'h182A,0)};
      vecs[5]  = '{32'h10220003, 1, mk(1,0,0,0,0,1,0,0,0,3'b110,5'd1,5'd2,5'd0,32'h3,0)};
      vecs[6]  = '{32'hAC22FFFC, 1, mk(1,0,0,1,0,0,0,1,0,3'b010,5'd1,5'd2,5'd31,32'hFFFFFFFC,0)};
      vecs[7]  = '{32'h08000010, 1, mk(1,0,0,0,0,0,1,0,0,3'b010,5'd0,5'd0,5'd0,32'h10,0)};
      vecs[8]  = '{32'h00221821, 1, mk(1,0,0,0,0,0,0,0,0,3'b011,5'd1,5'd2,5'd3,32'h1821,1)};
      vecs[9]  = '{32'hFC220005, 1, mk(1,0,0,0,0,0,0,0,0,3'b011,5'd1,5'd2,5'd0,32'h5,1)};
      vecs[10] = '{32'h00221820, 0, bubble};
      vecs[11] = '{32'h1022FFFE, 1, mk(1,0,0,0,0,1,0,0,0,3'b110,5'd1,5'd2,5'd31,32'hFFFFFFFE,0)};
`ifdef CTRL_IMM_OPS_EN
      vecs[12] = '{32'h2022FFFF, 1, mk(1,1,0,0,0,0,0,1,0,3'b010,5'd1,5'd2,5'd31,32'hFFFFFFFF,0)};
      vecs[13] = '{32'h3422FFFF, 1, mk(1,1,0,0,0,0,0,1,0,3'b001,5'd1,5'd2,5'd31,32'h0000FFFF,0)};
      vecs[14] = '{32'h2822FFFF, 1, mk(1,1,0,0,0,0,0,1,0,3'b111,5'd1,5'd2,5'd31,32'hFFFFFFFF,0)};
      vecs[15] = '{32'h3022FFFF, 1, mk(1,1,0,0,0,0,0,1,0,3'b000,5'd1,5'd2,5'd31,32'h0000FFFF,0)};
`else
      vecs[12] = '{32'h2022FFFF, 1, mk(1,0,0,0,0,0,0,0,0,3'b011,5'd1,5'd2,5'd31,32'h0000FFFF,1)};
      vecs[13] = '{32'h3422FFFF, 1, mk(1,0,0,0,0,0,0,0,0,3'b011,5'd1,5'd2,5'd31,32'h0000FFFF,1)};
      vecs[14] = '{32'h2822FFFF, 1, mk(1,0,0,0,0,0,0,0,0,3'b011,5'd1,5'd2,5'd31,32'h0000FFFF,1)};
      vecs[15] = '{32'h3022FFFF, 1, mk(1,0,0,0,0,0,0,0,0,3'b011,5'd1,5'd2,5'd31,32'h0000FFFF,1)};
`endif
      vecs[16] = '{I_LW, 1, lw_exp};

      // Reset state
      reset_n     = 1'b0;
      if_id_valid = 1'b0;
      if_id_instr = 32'h0;
      ex_stall_i  = 1'b0;
      flush_i     = 1'b0;
      cycle();
      cycle();
      check_vec("reset_state", bubble);
      check_bit("reset_hazard_stall", hazard_stall_o, 1'b0);
      reset_n = 1'b1;
      cycle();
      check_vec("after_release", bubble);

      // Single-instruction decode table
      for (int i = 0; i < 17; i++) begin
         if_id_instr = vecs[i].instr;
         if_id_valid = vecs[i].valid;
         cycle();
         check_vec($sformatf("vec%0d_%h", i, vecs[i].instr), vecs[i].exp);
      end

      // Mid-stream asynchronous reset with a load in EX and a pending hazard
      if_id_instr = I_ADD_R2;
      if_id_valid = 1'b1;
      #1;
      check_bit("pre_reset_hazard", hazard_stall_o, 1'b1);
      #1;
      reset_n = 1'b0;
      #1;
      check_vec("async_reset_bubble", bubble);
      check_bit("async_reset_hazard", hazard_stall_o, 1'b0);
      cycle();
      reset_n     = 1'b1;
      if_id_valid = 1'b0;
      cycle();
      check_vec("post_reset_bubble", bubble);

      // Load-use: exactly one bubble, then the add issues
      if_id_instr = I_LW;
      if_id_valid = 1'b1;
      cycle();
      check_vec("lu_lw_in_ex", lw_exp);
      if_id_instr = I_ADD_R2;
      #1;
      check_bit("lu_hazard_raised", hazard_stall_o, 1'b1);
      cycle();
      check_vec("lu_bubble", bubble);
      check_bit("lu_hazard_cleared", hazard_stall_o, 1'b0);
      cycle();
      check_vec("lu_add_issued", add_r2_exp);

      // Load followed by a load reusing rt as destination: rt is not a source
      if_id_instr = I_LW;
      cycle();
      if_id_instr = 32'h8C620000;  // lw $2,0($3)
      #1;
      check_bit("lw_rt_not_source", hazard_stall_o, 1'b0);
      cycle();
      check_vec("lw_lw_issued", mk(1,1,1,0,1,0,0,1,0,3'b010,5'd3,5'd2,5'd0,32'h0,0));

      // Load to $0 never causes a hazard
      if_id_instr = 32'h8C200004;  // lw $0,4($1)
      cycle();
      if_id_instr = 32'h00001820;  // add $3,$0,$0
      #1;
      check_bit("lw_r0_no_hazard", hazard_stall_o, 1'b0);
      cycle();
      check_vec("add_r0_issued", mk(1,1,0,0,0,0,0,0,1,3'b010,5'd0,5'd0,5'd3,32'h1820,0));

      // Downstream stall holds ID/EX; flush then beats stall and hazard
      if_id_instr = I_LW;
      cycle();
      if_id_instr = I_ADD_R2;
      ex_stall_i  = 1'b1;
      #1;
      check_bit("stall_hazard_out", hazard_stall_o, 1'b1);
      cycle();
      check_vec("stall_hold", lw_exp);
      flush_i = 1'b1;
      #1;
      check_bit("flush_no_stall_out", hazard_stall_o, 1'b0);
      cycle();
      check_vec("flush_bubble", bubble);
      flush_i    = 1'b0;
      ex_stall_i = 1'b0;
      #1;
      check_bit("post_flush_no_hazard", hazard_stall_o, 1'b0);
      cycle();
      check_vec("post_flush_add", add_r2_exp);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
